reg_file_mp: RTL and testbench

- Parametrised multi-port register file for the pipelined MIPS datapath; successor to the single-write, 2-read register file.
- Configurable data width, depth, read-port count and optional $zero register.
- Two write ports, for the ALU and memory writeback paths, plus an optional write-to-read bypass.
- A per-register busy scoreboard: the decode stage sets busy on issue, writeback clears it; read ports report busy for hazard stall logic.

---
 rtl/reg_file_mp_pkg.sv | 16 +
 rtl/reg_file_mp_if.sv | 31 +++
 rtl/reg_file_mp_scoreboard.sv | 52 +++++
 rtl/reg_file_mp.sv | 89 ++++++++
 tb/tb_reg_file_mp.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types and constants for the multi-port register file.
// Holds default-width typedefs and writeback port indices.
package reg_file_mp_pkg;

  localparam int P_DW    = 32;
  localparam int P_DEPTH = 32;
  localparam int P_AW    = $clog2(P_DEPTH);

  typedef logic [P_AW-1:0] reg_addr_t;
  typedef logic [P_DW-1:0] word_t;

  localparam int WB_PORT_ALU = 0;
  localparam int WB_PORT_MEM = 1;
  localparam int ZERO_ADDR   = 0;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus between pipeline (master) and register file (slave).
// Carries read ports, two writeback ports, issue/flush and busy_vec.
interface reg_file_mp_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NR    = 2,
  parameter int DEPTH = 32
);
  logic [NR*AW-1:0] rd_reg;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [1:0]       wr_en;
  logic [2*AW-1:0]  wr_reg;
  logic [2*DW-1:0]  wr_data;
  logic             issue_en;
  logic [AW-1:0]    issue_reg;
  logic             flush;
  logic [DEPTH-1:0] busy_vec;

  modport master (
    output rd_reg, wr_en, wr_reg, wr_data,
    output issue_en, issue_reg, flush,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_reg, wr_en, wr_reg, wr_data,
    input  issue_en, issue_reg, flush,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy bits: flush > issue > writeback clear > hold.
// Ports: clk, rst (sync active-low), issue, writeback, flush, busy_vec.
module reg_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_reg,
  input  logic [1:0]       wr_en,
  input  logic [2*AW-1:0]  wr_reg,
  input  logic             flush,
  output logic [DEPTH-1:0] busy_vec
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW-1:0]    wa_alu;
  logic [AW-1:0]    wa_mem;

  assign wa_alu = wr_reg[WB_PORT_ALU*AW +: AW];
  assign wa_mem = wr_reg[WB_PORT_MEM*AW +: AW];

  always_comb begin
    busy_nxt = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (issue_en && issue_reg == AW'(r))
        busy_nxt[r] = 1'b1;
      else if ((wr_en[WB_PORT_ALU] && wa_alu == AW'(r)) ||
               (wr_en[WB_PORT_MEM] && wa_mem == AW'(r)))
        busy_nxt[r] = 1'b0;
    end
    if (flush)
      busy_nxt = '0;
    if (ZERO_REG != 0)
      busy_nxt[ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      busy_q <= '0;
    else
      busy_q <= busy_nxt;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: 2 writeback ports, NR read ports, bypass.
// Ports: clk, rst (sync active-low), bus (reg_file_mp_if.slave).
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic        clk,
  input  logic        rst,
  reg_file_mp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]    regs [DEPTH];
  logic [AW-1:0]    wa_alu;
  logic [AW-1:0]    wa_mem;
  logic [DW-1:0]    wd_alu;
  logic [DW-1:0]    wd_mem;
  logic             we_alu;
  logic             we_mem;
  logic [DEPTH-1:0] busy;

  assign wa_alu = bus.wr_reg[WB_PORT_ALU*AW +: AW];
  assign wa_mem = bus.wr_reg[WB_PORT_MEM*AW +: AW];
  assign wd_alu = bus.wr_data[WB_PORT_ALU*DW +: DW];
  assign wd_mem = bus.wr_data[WB_PORT_MEM*DW +: DW];
  assign we_alu = bus.wr_en[WB_PORT_ALU] &&
                  !(ZERO_REG != 0 && wa_alu == AW'(ZERO_ADDR));
  assign we_mem = bus.wr_en[WB_PORT_MEM] &&
                  !(ZERO_REG != 0 && wa_mem == AW'(ZERO_ADDR));

  // MEM port applied last so it wins a same-register collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      if (we_alu)
        regs[wa_alu] <= wd_alu;
      if (we_mem)
        regs[wa_mem] <= wd_mem;
    end
  end

  reg_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .issue_en  (bus.issue_en),
    .issue_reg (bus.issue_reg),
    .wr_en     (bus.wr_en),
    .wr_reg    (bus.wr_reg),
    .flush     (bus.flush),
    .busy_vec  (busy)
  );

  assign bus.busy_vec = busy;

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    assign a = bus.rd_reg[k*AW +: AW];

    always_comb begin
      d = regs[a];
      if (BYPASS != 0) begin
        if (we_alu && wa_alu == a)
          d = wd_alu;
        if (we_mem && wa_mem == a)
          d = wd_mem;
      end
      if (ZERO_REG != 0 && a == AW'(ZERO_ADDR))
        d = '0;
    end

    assign bus.rd_data[k*DW +: DW] = d;
    assign bus.rd_busy[k]          = busy[a];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: vector table plus sequences.
// Covers bypass, collision, zero reg, scoreboard, flush, reset.
module tb_reg_file_mp;
  import reg_file_mp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DW(32), .AW(5), .NR(2), .DEPTH(32)) b0 ();
  reg_file_mp_if #(.DW(32), .AW(5), .NR(4), .DEPTH(32)) b1 ();

  reg_file_mp #(
    .DW(32), .DEPTH(32), .NR(2), .ZERO_REG(1), .BYPASS(1)
  ) u0 (.clk(clk), .rst(rst), .bus(b0.slave));

  reg_file_mp #(
    .DW(32), .DEPTH(32), .NR(4), .ZERO_REG(1), .BYPASS(0)
  ) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [4:0]  wa1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        ie;
    logic [4:0]  ir;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic        eb0;
    logic [31:0] ed1;
    logic        eb1;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.wr_en     = '0;
    b0.wr_reg    = '0;
    b0.wr_data   = '0;
    b0.issue_en  = 1'b0;
    b0.issue_reg = '0;
    b0.flush     = 1'b0;
    b1.wr_en     = '0;
    b1.wr_reg    = '0;
    b1.wr_data   = '0;
    b1.issue_en  = 1'b0;
    b1.issue_reg = '0;
    b1.flush     = 1'b0;
  endtask

  task automatic wr(int p, logic [4:0] a, logic [31:0] d);
    b0.wr_en[p]          = 1'b1;
    b0.wr_reg[p*5 +: 5]  = a;
    b0.wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(logic [4:0] a0, logic [4:0] a1);
    b0.rd_reg = {a1, a0};
  endtask

  initial begin
    idle();
    b0.rd_reg = '0;
    b1.rd_reg = '0;
    tbl[0] = '{2'b01, 5'd1, 5'd0, 32'h11, 32'h0, 1'b0, 5'd0,
               5'd1, 5'd2, 32'h11, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd2,
               5'd1, 5'd2, 32'h11, 1'b0, 32'h0, 1'b0};
    tbl[2] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
               5'd2, 5'd1, 32'h0, 1'b1, 32'h11, 1'b0};
    tbl[3] = '{2'b10, 5'd0, 5'd2, 32'h0, 32'h22, 1'b0, 5'd0,
               5'd2, 5'd2, 32'h22, 1'b1, 32'h22, 1'b1};
    tbl[4] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
               5'd2, 5'd1, 32'h22, 1'b0, 32'h11, 1'b0};
    tbl[5] = '{2'b11, 5'd7, 5'd7, 32'h1111, 32'h2222, 1'b0, 5'd0,
               5'd7, 5'd0, 32'h2222, 1'b0, 32'h0, 1'b0};
    tbl[6] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
               5'd7, 5'd7, 32'h2222, 1'b0, 32'h2222, 1'b0};
    tbl[7] = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd0,
               5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[8] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
               5'd0, 5'd7, 32'h0, 1'b0, 32'h2222, 1'b0};

    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    rd(5'd1, 5'd31);
    #1;
    chk("rst_d0", b0.rd_data[31:0], 64'h0);
    chk("rst_d1", b0.rd_data[63:32], 64'h0);
    chk("rst_b", b0.rd_busy, 64'h0);
    chk("rst_vec", b0.busy_vec, 64'h0);

    for (int i = 0; i < 9; i++) begin
      idle();
      b0.wr_en     = tbl[i].we;
      b0.wr_reg    = {tbl[i].wa1, tbl[i].wa0};
      b0.wr_data   = {tbl[i].wd1, tbl[i].wd0};
      b0.issue_en  = tbl[i].ie;
      b0.issue_reg = tbl[i].ir;
      rd(tbl[i].ra0, tbl[i].ra1);
      #1;
      chk($sformatf("v%0d_d0", i), b0.rd_data[31:0], tbl[i].ed0);
      chk($sformatf("v%0d_b0", i), b0.rd_busy[0], tbl[i].eb0);
      chk($sformatf("v%0d_d1", i), b0.rd_data[63:32], tbl[i].ed1);
      chk($sformatf("v%0d_b1", i), b0.rd_busy[1], tbl[i].eb1);
      tick();
    end
    idle();
    #1;
    chk("zero_vec", b0.busy_vec[0], 64'h0);

    // scoreboard timing on r3
    b0.issue_en  = 1'b1;
    b0.issue_reg = 5'd3;
    rd(5'd3, 5'd3);
    #1;
    chk("sb_pre", b0.rd_busy[0], 64'h0);
    tick();
    idle();
    for (int c = 1; c < 4; c++) begin
      #1;
      chk($sformatf("sb_n%0d", c), b0.rd_busy[0], 64'h1);
      tick();
    end
    wr(WB_PORT_ALU, 5'd3, 32'h33);
    #1;
    chk("sb_wr_d", b0.rd_data[31:0], 64'h33);
    chk("sb_wr_b", b0.rd_busy[0], 64'h1);
    tick();
    idle();
    #1;
    chk("sb_clr", b0.rd_busy[0], 64'h0);
    chk("sb_data", b0.rd_data[31:0], 64'h33);
    b0.issue_en  = 1'b1;
    b0.issue_reg = 5'd3;
    wr(WB_PORT_ALU, 5'd3, 32'h34);
    tick();
    idle();
    #1;
    chk("sb_iss_wins", b0.rd_busy[0], 64'h1);
    wr(WB_PORT_MEM, 5'd3, 32'h35);
    tick();
    idle();
    #1;
    chk("sb_mem_clr", b0.rd_busy[1], 64'h0);

    // flush
    wr(WB_PORT_ALU, 5'd4, 32'h4);
    wr(WB_PORT_MEM, 5'd9, 32'h9);
    tick();
    idle();
    wr(WB_PORT_ALU, 5'd12, 32'hC);
    tick();
    idle();
    b0.issue_en = 1'b1;
    b0.issue_reg = 5'd4;
    tick();
    b0.issue_reg = 5'd9;
    tick();
    b0.issue_reg = 5'd12;
    tick();
    idle();
    #1;
    chk("fl_pre", b0.busy_vec, 64'h1210);
    b0.flush     = 1'b1;
    b0.issue_en  = 1'b1;
    b0.issue_reg = 5'd5;
    tick();
    idle();
    rd(5'd4, 5'd9);
    #1;
    chk("fl_vec", b0.busy_vec, 64'h0);
    chk("fl_r4", b0.rd_data[31:0], 64'h4);
    chk("fl_r9", b0.rd_data[63:32], 64'h9);
    rd(5'd12, 5'd3);
    #1;
    chk("fl_r12", b0.rd_data[31:0], 64'hC);

    // reset mid-operation
    wr(WB_PORT_ALU, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    b0.issue_en  = 1'b1;
    b0.issue_reg = 5'd6;
    rd(5'd5, 5'd6);
    tick();
    idle();
    #1;
    chk("mr_r5", b0.rd_data[31:0], 64'hDEADBEEF);
    chk("mr_b6", b0.rd_busy[1], 64'h1);
    rst = 1'b0;
    wr(WB_PORT_MEM, 5'd9, 32'h1);
    b0.issue_en  = 1'b1;
    b0.issue_reg = 5'd8;
    tick();
    tick();
    rst = 1'b1;
    idle();
    #1;
    chk("mr_rst_r5", b0.rd_data[31:0], 64'h0);
    chk("mr_rst_vec", b0.busy_vec, 64'h0);
    rd(5'd9, 5'd6);
    #1;
    chk("mr_rst_r9", b0.rd_data[31:0], 64'h0);
    wr(WB_PORT_ALU, 5'd6, 32'h66);
    tick();
    idle();
    #1;
    chk("mr_late_d", b0.rd_data[63:32], 64'h66);
    chk("mr_late_b", b0.busy_vec, 64'h0);

    // no-bypass build, 4 read ports
    b1.rd_reg = {4{5'd10}};
    b1.wr_en  = 2'b01;
    b1.wr_reg = {5'd0, 5'd10};
    b1.wr_data = {32'h0, 32'h12345678};
    tick();
    b1.wr_data = {32'h0, 32'hA5A5A5A5};
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("nb_old%0d", k),
          b1.rd_data[k*32 +: 32], 64'h12345678);
    tick();
    idle();
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("nb_new%0d", k),
          b1.rd_data[k*32 +: 32], 64'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
